// File: rtl/mips_pipeline_fwd_if.sv
// Instruction and data memory bus of the pipelined MIPS core.
// The core drives addresses and strobes (master); the memory system returns
// combinational read data (slave).
interface mips_pipeline_fwd_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_we;
  logic        dmem_re;
  logic [31:0] dmem_rdata;

  modport master (
    output imem_addr,
    input  imem_rdata,
    output dmem_addr,
    output dmem_wdata,
    output dmem_we,
    output dmem_re,
    input  dmem_rdata
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    input  dmem_addr,
    input  dmem_wdata,
    input  dmem_we,
    input  dmem_re,
    output dmem_rdata
  );
endinterface

// File: rtl/mips_pipeline_fwd.sv
// 5-stage MIPS core (IF/ID/EX/MEM/WB) with operand forwarding, load-use and
// RAW interlocks, branch squash (beq resolved in MEM), jump squash (j in ID)
// and a writeback trace port. ISA: add sub and or slt lw sw beq j.
module mips_pipeline_fwd #(
  parameter bit          FORWARD_EN = 1'b1,
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter bit          RF_BYPASS  = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  mips_pipeline_fwd_if.master        bus,
  output logic                       wb_valid,
  output logic [4:0]                 wb_rd,
  output logic [31:0]                wb_data,
  output logic                       stall,
  output logic                       flush
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_LW = 6'h23, OP_SW = 6'h2b
  } opcode_e;
  typedef enum logic [5:0] {
    FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2a
  } funct_e;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;
  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic use_imm;
  } ctrl_t;

  logic [31:0] rf [32];
  logic [31:0] pc, pc_plus4;
  // IF/ID
  logic [31:0] ifid_instr, ifid_pc4;
  // ID/EX
  ctrl_t       idex_ctrl;
  alu_op_e     idex_alu;
  logic [4:0]  idex_rs, idex_rt, idex_rd;
  logic [31:0] idex_a, idex_b, idex_imm, idex_pc4;
  // EX/MEM
  logic        exmem_reg_write, exmem_mem_read, exmem_mem_write, exmem_branch, exmem_zero;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_alu, exmem_wdata, exmem_btgt;
  // MEM/WB
  logic        memwb_reg_write;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_data;

  // ID-stage decode results
  ctrl_t       id_ctrl;
  alu_op_e     id_alu;
  logic [4:0]  id_rs, id_rt, id_dst;
  logic        id_use_rs, id_use_rt, id_jump;
  logic [31:0] id_a, id_b, id_imm, id_jtgt;
  // EX / MEM / hazard results
  logic [31:0] fwd_a, fwd_b, alu_b, alu_res, ex_btgt, mem_data;
  logic        taken, hazard;

  // True when dst is a live (non-$0) register that the ID instruction reads.
  function automatic logic id_reads(input logic [4:0] dst, input logic [4:0] rs,
                                    input logic [4:0] rt, input logic use_rs,
                                    input logic use_rt);
    return (dst != '0) && ((use_rs && dst == rs) || (use_rt && dst == rt));
  endfunction

  assign pc_plus4 = pc + 32'd4;
  assign id_rs    = ifid_instr[25:21];
  assign id_rt    = ifid_instr[20:16];
  assign id_imm   = {{16{ifid_instr[15]}}, ifid_instr[15:0]};
  assign id_jtgt  = {ifid_pc4[31:28], ifid_instr[25:0], 2'b00};

  // Decode; anything unrecognised (including the all-zero bubble) gets no control bits.
  always_comb begin
    id_ctrl   = '0;
    id_alu    = ALU_ADD;
    id_dst    = '0;
    id_use_rs = 1'b0;
    id_use_rt = 1'b0;
    id_jump   = 1'b0;
    case (ifid_instr[31:26])
      OP_RTYPE: begin
        case (ifid_instr[5:0])
          FN_ADD:  id_alu = ALU_ADD;
          FN_SUB:  id_alu = ALU_SUB;
          FN_AND:  id_alu = ALU_AND;
          FN_OR:   id_alu = ALU_OR;
          FN_SLT:  id_alu = ALU_SLT;
          default: id_alu = ALU_ADD;
        endcase
        if (ifid_instr[5:0] inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT}) begin
          id_ctrl.reg_write = 1'b1;
          id_dst            = ifid_instr[15:11];
          id_use_rs         = 1'b1;
          id_use_rt         = 1'b1;
        end
      end
      OP_LW: begin
        id_ctrl.reg_write = 1'b1;
        id_ctrl.mem_read  = 1'b1;
        id_ctrl.use_imm   = 1'b1;
        id_dst            = id_rt;
        id_use_rs         = 1'b1;
      end
      OP_SW: begin
        id_ctrl.mem_write = 1'b1;
        id_ctrl.use_imm   = 1'b1;
        id_use_rs         = 1'b1;
        id_use_rt         = 1'b1;
      end
      OP_BEQ: begin
        id_ctrl.branch = 1'b1;
        id_alu         = ALU_SUB;
        id_use_rs      = 1'b1;
        id_use_rt      = 1'b1;
      end
      OP_J:    id_jump = 1'b1;
      default: ;
    endcase
  end

  // Register file read with optional write-first bypass from WB; $0 reads as zero.
  always_comb begin
    id_a = '0;
    id_b = '0;
    if (id_rs != '0)
      id_a = (RF_BYPASS && memwb_reg_write && memwb_rd == id_rs) ? memwb_data : rf[id_rs];
    if (id_rt != '0)
      id_b = (RF_BYPASS && memwb_reg_write && memwb_rd == id_rt) ? memwb_data : rf[id_rt];
  end

  // Hazard detection. Without the RF bypass a WB-stage producer is still invisible
  // to ID, so it interlocks as well.
  always_comb begin
    hazard = 1'b0;
    if (FORWARD_EN)
      hazard = idex_ctrl.mem_read && id_reads(idex_rd, id_rs, id_rt, id_use_rs, id_use_rt);
    else
      hazard = (idex_ctrl.reg_write && id_reads(idex_rd, id_rs, id_rt, id_use_rs, id_use_rt)) ||
               (exmem_reg_write && id_reads(exmem_rd, id_rs, id_rt, id_use_rs, id_use_rt));
    if (!RF_BYPASS && memwb_reg_write && id_reads(memwb_rd, id_rs, id_rt, id_use_rs, id_use_rt))
      hazard = 1'b1;
  end

  // EX stage: operand bypass (EX/MEM over MEM/WB), ALU and branch target.
  always_comb begin
    fwd_a = idex_a;
    fwd_b = idex_b;
    if (FORWARD_EN && exmem_reg_write && exmem_rd != '0 && exmem_rd == idex_rs)
      fwd_a = exmem_alu;
    else if (FORWARD_EN && memwb_reg_write && memwb_rd != '0 && memwb_rd == idex_rs)
      fwd_a = memwb_data;
    if (FORWARD_EN && exmem_reg_write && exmem_rd != '0 && exmem_rd == idex_rt)
      fwd_b = exmem_alu;
    else if (FORWARD_EN && memwb_reg_write && memwb_rd != '0 && memwb_rd == idex_rt)
      fwd_b = memwb_data;
    alu_b = idex_ctrl.use_imm ? idex_imm : fwd_b;
    case (idex_alu)
      ALU_SUB: alu_res = fwd_a - alu_b;
      ALU_AND: alu_res = fwd_a & alu_b;
      ALU_OR:  alu_res = fwd_a | alu_b;
      ALU_SLT: alu_res = {31'd0, $signed(fwd_a) < $signed(alu_b)};
      default: alu_res = fwd_a + alu_b;
    endcase
    ex_btgt = idex_pc4 + {idex_imm[29:0], 2'b00};
  end

  assign taken    = exmem_branch && exmem_zero;
  assign mem_data = exmem_mem_read ? bus.dmem_rdata : exmem_alu;

  assign bus.imem_addr  = pc;
  assign bus.dmem_addr  = exmem_alu;
  assign bus.dmem_wdata = exmem_wdata;
  assign bus.dmem_we    = exmem_mem_write && !reset;
  assign bus.dmem_re    = exmem_mem_read && !reset;
  assign wb_valid       = memwb_reg_write;
  assign wb_rd          = memwb_rd;
  assign wb_data        = memwb_data;
  assign stall          = hazard && !taken;
  assign flush          = taken || id_jump;

  // PC and pipeline control bits: reset > taken branch > jump > stall > advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc              <= RESET_PC;
      ifid_instr      <= '0;
      ifid_pc4        <= '0;
      idex_ctrl       <= '0;
      exmem_reg_write <= 1'b0;
      exmem_mem_read  <= 1'b0;
      exmem_mem_write <= 1'b0;
      exmem_branch    <= 1'b0;
      memwb_reg_write <= 1'b0;
    end else begin
      memwb_reg_write <= exmem_reg_write;
      if (taken) begin
        pc              <= exmem_btgt;
        ifid_instr      <= '0;
        idex_ctrl       <= '0;
        exmem_reg_write <= 1'b0;
        exmem_mem_read  <= 1'b0;
        exmem_mem_write <= 1'b0;
        exmem_branch    <= 1'b0;
      end else begin
        exmem_reg_write <= idex_ctrl.reg_write;
        exmem_mem_read  <= idex_ctrl.mem_read;
        exmem_mem_write <= idex_ctrl.mem_write;
        exmem_branch    <= idex_ctrl.branch;
        if (id_jump) begin
          pc         <= id_jtgt;
          ifid_instr <= '0;
          idex_ctrl  <= '0;
        end else if (hazard) begin
          idex_ctrl <= '0;
        end else begin
          pc         <= pc_plus4;
          ifid_instr <= bus.imem_rdata;
          ifid_pc4   <= pc_plus4;
          idex_ctrl  <= id_ctrl;
        end
      end
    end
  end

  // Datapath fields; these are don't-care whenever the matching control bits are zero.
  always_ff @(posedge clk) begin
    idex_alu    <= id_alu;
    idex_rs     <= id_rs;
    idex_rt     <= id_rt;
    idex_rd     <= id_dst;
    idex_a      <= id_a;
    idex_b      <= id_b;
    idex_imm    <= id_imm;
    idex_pc4    <= ifid_pc4;
    exmem_zero  <= (alu_res == '0);
    exmem_rd    <= idex_rd;
    exmem_alu   <= alu_res;
    exmem_wdata <= fwd_b;
    exmem_btgt  <= ex_btgt;
    memwb_rd    <= exmem_rd;
    memwb_data  <= mem_data;
  end

  // Register file write from WB; the reset cycle commits nothing.
  always_ff @(posedge clk) begin
    if (!reset && memwb_reg_write && memwb_rd != '0)
      rf[memwb_rd] <= memwb_data;
  end

endmodule
